// File: rtl/uart_wb_pkg.sv
// uart_wb_pkg: shared definitions for the UART-to-Wishbone command sequencer.
//   wb_state_e       - sequencer state encoding (IDLE, DATA, BUS, REPLY)
//   CMD_WRITE_BIT    - command byte bit selecting write (1) or read (0)
//   DEFAULT_ERR_BYTE - default reply byte sent when a bus access times out
package uart_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_BUS   = 2'd2,
        ST_REPLY = 2'd3
    } wb_state_e;

    localparam int unsigned    CMD_WRITE_BIT    = 7;
    localparam logic [7:0]     DEFAULT_ERR_BYTE = 8'hEE;

endpackage

// File: rtl/uart_wb_timeout.sv
// uart_wb_timeout: bus-cycle watchdog for the UART Wishbone master.
// Counts enabled cycles from a clear; expired is high while the count equals
// TIMEOUT_CYCLES-1, i.e. during the TIMEOUT_CYCLES-th enabled cycle.
// Only instantiated when UART_WB_TIMEOUT_EN is defined.
//   clock   in  system clock
//   reset   in  synchronous, active-high reset
//   clear   in  return the count to zero
//   enable  in  advance the count by one this cycle
//   expired out count has reached TIMEOUT_CYCLES-1
module uart_wb_timeout
    import uart_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    // Holds at LAST so the flag stays up if the owner lingers after expiry.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_wb_master.sv
// uart_wb_master: turns UART command bytes into single Wishbone classic
// transactions and returns read data through the UART transmitter.
// Command byte: bit7 = 1 write (a data byte follows), 0 read;
// bits [ADDR_WIDTH-1:0] address; remaining bits ignored.
// Optional bus timeout: define UART_WB_TIMEOUT_EN.
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   rx_data, rx_valid        received byte and its one-cycle strobe
//   tx_data, tx_valid        reply byte, held until tx_ready accepts it
//   tx_ready                 transmitter ready
//   wb_cyc, wb_stb, wb_we    Wishbone control (stb mirrors cyc)
//   wb_adr, wb_dat_o         Wishbone address and write data
//   wb_dat_i, wb_ack         Wishbone read data and acknowledge
//   busy                     sequencer not idle
//   rx_dropped               pulse: a byte arrived while BUS/REPLY and was discarded
//   bus_error                sticky timeout flag (0 without UART_WB_TIMEOUT_EN)
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ERR_BYTE       = DEFAULT_ERR_BYTE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic [7:0]            wb_dat_o,
    input  logic [7:0]            wb_dat_i,
    input  logic                  wb_ack,
    output logic                  busy,
    output logic                  rx_dropped,
    output logic                  bus_error
);

    wb_state_e             state, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  we_q, we_d;
    logic [7:0]            dat_q, dat_d;
    logic [7:0]            txd_q, txd_d;
    logic                  tmo_expired;

`ifdef UART_WB_TIMEOUT_EN
    logic berr_q;

    uart_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != ST_BUS),
        .enable  (state == ST_BUS),
        .expired (tmo_expired)
    );

    // An ack in the expiry cycle wins, so the error is only flagged without one.
    always_ff @(posedge clock) begin
        if (reset) begin
            berr_q <= 1'b0;
        end else if (state == ST_BUS && !wb_ack && tmo_expired) begin
            berr_q <= 1'b1;
        end
    end

    assign bus_error = berr_q;
`else
    assign tmo_expired = 1'b0;
    assign bus_error   = 1'b0;
`endif

    // Bus and reply handshakes are decoded from state so that a reset or a
    // state change removes them on the very next edge.
    assign wb_cyc   = (state == ST_BUS);
    assign wb_stb   = wb_cyc;
    assign tx_valid = (state == ST_REPLY);
    assign busy     = (state != ST_IDLE);
    assign wb_we    = we_q;
    assign wb_adr   = adr_q;
    assign wb_dat_o = dat_q;
    assign tx_data  = txd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            adr_q      <= '0;
            we_q       <= 1'b0;
            dat_q      <= '0;
            txd_q      <= '0;
            rx_dropped <= 1'b0;
        end else begin
            state      <= state_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            dat_q      <= dat_d;
            txd_q      <= txd_d;
            rx_dropped <= rx_valid && (state == ST_BUS || state == ST_REPLY);
        end
    end

    always_comb begin
        state_d = state;
        adr_d   = adr_q;
        we_d    = we_q;
        dat_d   = dat_q;
        txd_d   = txd_q;

        unique case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    adr_d   = rx_data[ADDR_WIDTH-1:0];
                    we_d    = rx_data[CMD_WRITE_BIT];
                    state_d = rx_data[CMD_WRITE_BIT] ? ST_DATA : ST_BUS;
                end
            end

            ST_DATA: begin
                if (rx_valid) begin
                    dat_d   = rx_data;
                    state_d = ST_BUS;
                end
            end

            ST_BUS: begin
                if (wb_ack) begin
                    if (we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        txd_d   = wb_dat_i;
                        state_d = ST_REPLY;
                    end
                end else if (tmo_expired) begin
                    // Reads and writes alike report the timeout to the host.
                    txd_d   = ERR_BYTE;
                    state_d = ST_REPLY;
                end
            end

            ST_REPLY: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: self-checking bench for uart_wb_master.
// Expected bus transactions and reply bytes are queued when commands are sent
// and compared when the DUT presents them. A behavioural Wishbone slave acks
// after a programmable number of strobe cycles.
`timescale 1ns/1ps
module tb_uart_wb_master;

    typedef struct {
        logic       we;
        logic [3:0] adr;
        logic [7:0] dat;
    } bus_txn_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       wb_cyc, wb_stb, wb_we;
    logic [3:0] wb_adr;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_ack = 1'b0;
    logic       busy, rx_dropped, bus_error;

    int tests = 0;
    int fails = 0;

    bus_txn_t   exp_bus[$];
    logic [7:0] exp_tx[$];

    int unsigned ack_delay = 0;
    logic [7:0]  rd_data   = 8'h00;
    logic        slave_en  = 1'b1;
    int unsigned slv_cnt   = 0;

    uart_wb_master #(
        .ADDR_WIDTH     (4),
        .TIMEOUT_CYCLES (8),
        .ERR_BYTE       (8'hEE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_adr     (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack     (wb_ack),
        .busy       (busy),
        .rx_dropped (rx_dropped),
        .bus_error  (bus_error)
    );

    always #5 clock = ~clock;

    // Slave: ack is raised in the (ack_delay+1)-th strobe cycle, for one cycle.
    always @(negedge clock) begin
        if (wb_ack) begin
            wb_ack  = 1'b0;
            slv_cnt = 0;
        end else if (wb_cyc && wb_stb && slave_en) begin
            if (slv_cnt == ack_delay) begin
                wb_ack   = 1'b1;
                wb_dat_i = rd_data;
            end
            slv_cnt++;
        end else if (!wb_cyc) begin
            slv_cnt = 0;
        end
    end

    // Called #1 after an edge; the byte is sampled at the next edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (!(wb_cyc && wb_ack) && n < 64) begin
            @(negedge clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({wb_cyc, wb_stb, wb_we, tx_valid, busy, rx_dropped, bus_error} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, want 0000000",
                     {wb_cyc, wb_stb, wb_we, tx_valid, busy, rx_dropped, bus_error});
        end
        tests++;
        if ({wb_adr, wb_dat_o, tx_data} !== 20'h0) begin
            fails++;
            $display("FAIL reset_data: got %h, want 00000", {wb_adr, wb_dat_o, tx_data});
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_read(input logic [7:0] cmd, input logic [7:0] data, input int unsigned delay);
        bus_txn_t   e;
        logic [7:0] t;
        int         n;
        ack_delay = delay;
        rd_data   = data;
        slave_en  = 1'b1;
        tx_ready  = 1'b1;
        exp_bus.push_back('{we: 1'b0, adr: cmd[3:0], dat: 8'h00});
        exp_tx.push_back(data);
        send_byte(cmd);
        tests++;
        if (wb_cyc !== 1'b1 || wb_stb !== 1'b1) begin
            fails++;
            $display("FAIL read_strobe_latency: cyc=%b stb=%b, want 1 1", wb_cyc, wb_stb);
        end
        wait_ack(n);
        e = exp_bus.pop_front();
        tests++;
        if (wb_we !== e.we || wb_adr !== e.adr) begin
            fails++;
            $display("FAIL read_bus: we=%b adr=%h, want we=%b adr=%h", wb_we, wb_adr, e.we, e.adr);
        end
        tests++;
        if (n != int'(delay) + 1) begin
            fails++;
            $display("FAIL read_strobe_cycles: got %0d, want %0d", n, delay + 1);
        end
        @(posedge clock); #1;
        tests++;
        if (wb_cyc !== 1'b0 || tx_valid !== 1'b1) begin
            fails++;
            $display("FAIL read_reply_enter: cyc=%b tx_valid=%b, want 0 1", wb_cyc, tx_valid);
        end
        t = exp_tx.pop_front();
        tests++;
        if (tx_data !== t) begin
            fails++;
            $display("FAIL read_data: got %h, want %h", tx_data, t);
        end
        @(posedge clock); #1;
        tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL read_done: busy=%b tx_valid=%b, want 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_write(input logic [7:0] cmd, input logic [7:0] data);
        bus_txn_t e;
        int       n;
        ack_delay = 0;
        slave_en  = 1'b1;
        exp_bus.push_back('{we: 1'b1, adr: cmd[3:0], dat: data});
        send_byte(cmd);
        tests++;
        if (busy !== 1'b1 || wb_cyc !== 1'b0) begin
            fails++;
            $display("FAIL write_wait_data: busy=%b cyc=%b, want 1 0", busy, wb_cyc);
        end
        send_byte(data);
        tests++;
        if (wb_cyc !== 1'b1) begin
            fails++;
            $display("FAIL write_strobe_latency: cyc=%b, want 1", wb_cyc);
        end
        wait_ack(n);
        e = exp_bus.pop_front();
        tests++;
        if (wb_we !== e.we || wb_adr !== e.adr || wb_dat_o !== e.dat || n != 1) begin
            fails++;
            $display("FAIL write_bus: we=%b adr=%h dat=%h cycles=%0d, want we=%b adr=%h dat=%h cycles=1",
                     wb_we, wb_adr, wb_dat_o, n, e.we, e.adr, e.dat);
        end
        @(posedge clock); #1;
        tests++;
        if (wb_cyc !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL write_done: cyc=%b busy=%b tx_valid=%b, want 0 0 0", wb_cyc, busy, tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        // Ignored command bits set; the read starts the cycle IDLE is re-entered.
        test_write(8'hFA, 8'h11);
        test_read(8'h7C, 8'hB6, 0);
    endtask

    task automatic test_backpressure();
        logic [7:0] t;
        int         n;
        ack_delay = 1;
        rd_data   = 8'h3C;
        slave_en  = 1'b1;
        tx_ready  = 1'b0;
        exp_tx.push_back(8'h3C);
        send_byte(8'h07);
        wait_ack(n);
        @(posedge clock); #1;
        t = exp_tx[0];
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== t || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: tx_valid=%b tx_data=%h busy=%b, want 1 %h 1",
                         i, tx_valid, tx_data, busy, t);
            end
            if (i == 3) begin
                rx_data  = 8'h81;
                rx_valid = 1'b1;
            end
            @(posedge clock); #1;
            rx_valid = 1'b0;
            tests++;
            if (rx_dropped !== (i == 3)) begin
                fails++;
                $display("FAIL bp_rx_dropped[%0d]: got %b, want %b", i, rx_dropped, (i == 3));
            end
        end
        tx_ready = 1'b1;
        t = exp_tx.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== t) begin
            fails++;
            $display("FAIL bp_transfer: tx_valid=%b tx_data=%h, want 1 %h", tx_valid, tx_data, t);
        end
        @(posedge clock); #1;
        tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_done: tx_valid=%b busy=%b, want 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_ack_drop();
        logic [7:0] t;
        ack_delay = 0;
        rd_data   = 8'hD2;
        slave_en  = 1'b1;
        tx_ready  = 1'b0;
        exp_tx.push_back(8'hD2);
        send_byte(8'h02);
        // Byte arrives in the same cycle the slave acks.
        send_byte(8'h84);
        t = exp_tx.pop_front();
        tests++;
        if (rx_dropped !== 1'b1 || tx_valid !== 1'b1 || tx_data !== t || wb_cyc !== 1'b0) begin
            fails++;
            $display("FAIL ack_drop: dropped=%b tx_valid=%b tx_data=%h cyc=%b, want 1 1 %h 0",
                     rx_dropped, tx_valid, tx_data, wb_cyc, t);
        end
        tx_ready = 1'b1;
        @(posedge clock); #1;
        tests++;
        if (busy !== 1'b0 || rx_dropped !== 1'b0) begin
            fails++;
            $display("FAIL ack_drop_done: busy=%b dropped=%b, want 0 0", busy, rx_dropped);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        // Mid-BUS: slave never answers.
        slave_en = 1'b0;
        send_byte(8'h01);
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (wb_cyc !== 1'b1) begin
            fails++;
            $display("FAIL rst_bus_pre: cyc=%b, want 1", wb_cyc);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        tests++;
        if (wb_cyc !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_bus: cyc=%b tx_valid=%b busy=%b, want 0 0 0", wb_cyc, tx_valid, busy);
        end
        // Mid-REPLY: reply pending, then reset; no reply may follow.
        slave_en  = 1'b1;
        ack_delay = 0;
        rd_data   = 8'h99;
        tx_ready  = 1'b0;
        send_byte(8'h02);
        wait_ack(n);
        @(posedge clock); #1;
        tests++;
        if (tx_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_reply_pre: tx_valid=%b, want 1", tx_valid);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        tx_ready = 1'b1;
        tests++;
        if (wb_cyc !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_reply: cyc=%b tx_valid=%b busy=%b, want 0 0 0", wb_cyc, tx_valid, busy);
        end
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_reply: tx_valid=%b, want 0", tx_valid);
        end
        test_read(8'h04, 8'hA7, 1);
    endtask

`ifdef UART_WB_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] t;
        int         n;
        // Ack in the 8th strobe cycle wins over expiry.
        test_read(8'h06, 8'h42, 7);
        tests++;
        if (bus_error !== 1'b0) begin
            fails++;
            $display("FAIL tmo_ack_wins: bus_error=%b, want 0", bus_error);
        end
        slave_en = 1'b0;
        tx_ready = 1'b0;
        exp_tx.push_back(8'hEE);
        send_byte(8'h06);
        n = 0;
        while (wb_cyc && n < 64) begin
            n++;
            @(posedge clock); #1;
        end
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL tmo_cycles: strobes high %0d cycles, want 8", n);
        end
        t = exp_tx.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== t || bus_error !== 1'b1) begin
            fails++;
            $display("FAIL tmo_reply: tx_valid=%b tx_data=%h bus_error=%b, want 1 %h 1",
                     tx_valid, tx_data, bus_error, t);
        end
        tx_ready = 1'b1;
        @(posedge clock); #1;
        tests++;
        if (busy !== 1'b0 || bus_error !== 1'b1) begin
            fails++;
            $display("FAIL tmo_sticky: busy=%b bus_error=%b, want 0 1", busy, bus_error);
        end
        slave_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_read(8'h03, 8'h5A, 2);
        test_write(8'h85, 8'hC3);
        test_back_to_back();
        test_backpressure();
        test_ack_drop();
        test_reset_mid();
`ifdef UART_WB_TIMEOUT_EN
        test_timeout();
`endif
        tests++;
        if (bus_error !== 1'b0 && !`ifdef UART_WB_TIMEOUT_EN 1'b1 `else 1'b0 `endif) begin
            fails++;
            $display("FAIL bus_error_idle: got %b, want 0", bus_error);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Command sequencer that turns the byte stream from the UART receiver into single Wishbone classic transactions on the peripheral bus (LED, PWM servo and similar slaves).
- Sends read data back through the UART transmitter.
- Sits in top between the UART rx/tx blocks and the Wishbone interconnect.
- Is the only bus master, so the host drives every register through uart_rx/uart_tx.

Parameters:
- ADDR_WIDTH, 4, Wishbone address width. Legal range 1..7; address is taken from command bits [ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 255, maximum cycles to wait for wb_ack. Used only with UART_WB_TIMEOUT_EN.
- ERR_BYTE, 8'hEE, reply byte sent on a bus timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe; always equal to wb_cyc.
- wb_we  out  1  write enable.
- wb_adr  out  ADDR_WIDTH  address.
- wb_dat_o  out  8  write data.
- wb_dat_i  in  8  read data.
- wb_ack  in  1  slave acknowledge.
- busy  out  1  high whenever state != IDLE.
- rx_dropped  out  1  one-cycle pulse when a byte is discarded.
- bus_error  out  1  sticky timeout flag; cleared only by reset. Constant 0 when the timeout feature is compiled out.

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Reset mid-transaction drops wb_cyc/wb_stb and tx_valid on the next edge; no partial reply is sent.
- Command byte format:
  - bit7 = 1: write; bit7 = 0: read.
  - Bits [6:ADDR_WIDTH] are ignored.
  - Address is bits [ADDR_WIDTH-1:0].
- State IDLE:
  - rx_valid with bit7 = 0: latch address, clear wb_we, go to BUS.
  - rx_valid with bit7 = 1: latch address, set wb_we, go to DATA.
- State DATA: the next rx_valid latches wb_dat_o and goes to BUS. There is no timeout waiting for this byte.
- State BUS:
  - wb_cyc = wb_stb = 1 starting the cycle after entry. Latency: command/data byte at edge N, bus strobes high in cycle N+1.
  - wb_ack sampled high at edge M: strobes low from M+1, and wb_dat_i is captured at M for reads.
  - Read then goes to REPLY with tx_data = captured data. Write returns to IDLE; writes send no reply.
  - wb_ack is ignored outside BUS.
- State REPLY:
  - tx_valid = 1 with tx_data stable.
  - On an edge where tx_valid && tx_ready: tx_valid drops next cycle, go to IDLE.
  - If tx_ready is already high on the first REPLY cycle, the byte transfers in that cycle.
- Dropped bytes: rx_valid in BUS or REPLY discards the byte and pulses rx_dropped the following cycle. The state machine is not affected.
- Simultaneous rx_valid and wb_ack in BUS: the ack is processed and the byte is dropped.
- Back-to-back commands: a new command is accepted in the cycle IDLE is re-entered.

Optional Feature:
- Macro UART_WB_TIMEOUT_EN.
- When defined:
  - A counter clears on BUS entry and increments each BUS cycle.
  - If it reaches TIMEOUT_CYCLES-1 without wb_ack: drop strobes next cycle and set bus_error.
  - Both read and write then go to REPLY with tx_data = ERR_BYTE.
  - An ack in the same cycle as the expiry wins; the transaction completes normally with no error.
- When undefined: BUS waits indefinitely, no counter logic is present, and bus_error is tied to 0.

Decomposition:
- Package uart_wb_pkg holds:
  - State encoding: IDLE, DATA, BUS, REPLY.
  - CMD_WRITE_BIT = 7.
  - Default ERR_BYTE constant.
- One natural sub-module: uart_wb_timeout.
  - Counter with clear/enable/expired outputs, parameterised by TIMEOUT_CYCLES.
  - Instantiated only under UART_WB_TIMEOUT_EN.

Test Plan:
- Read: rx 8'h03, slave acks after 2 cycles with 8'h5A -> wb_adr = 3, wb_we = 0, strobes high 1 cycle after rx; tx_data = 8'h5A with tx_valid; busy low after the tx handshake.
- Write: rx 8'h85 then 8'hC3, immediate ack -> one bus cycle with wb_we = 1, wb_adr = 5, wb_dat_o = 8'hC3; no tx_valid; back in IDLE one cycle later.
- Backpressure: read reply with tx_ready low for 10 cycles -> tx_valid and tx_data held stable for 10 cycles; transfer on the first tx_ready; extra rx byte during the wait -> rx_dropped pulse, state unchanged.
- Timeout (UART_WB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): read with no ack -> strobes drop after 8 cycles, tx_data = 8'hEE, bus_error stays 1. Ack on the 8th cycle -> normal completion, bus_error = 0.
- Reset mid-BUS and mid-REPLY: assert reset -> next cycle wb_cyc = 0, tx_valid = 0, busy = 0; a following read command works normally.
